// File: rtl/regfile_pkg.sv
// Shared types and display-select codes for the register-file datapath.
package regfile_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  localparam logic [1:0] SEL_ADDR   = 2'd0;
  localparam logic [1:0] SEL_RDATA  = 2'd1;
  localparam logic [1:0] SEL_WDATA  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

endpackage

// File: rtl/regfile_ctrl_addr_counter.sv
// AW-bit up/down address pointer. It wraps modulo 2**AW.
// Simultaneous inc and dec cancel. load_zero takes priority over both.
module addr_counter #(
  parameter int AW = 4
) (
  input  logic          hwclk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          load_zero,
  output logic [AW-1:0] count
);

  logic [AW-1:0] r_count;

  // Pointer update: reset/load-zero first, then a single-direction step.
  always_ff @(posedge hwclk) begin
    if (reset || load_zero) begin
      r_count <= '0;
    end else if (inc && !dec) begin
      r_count <= r_count + 1'b1;
    end else if (dec && !inc) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file datapath behind the pushbutton FSM. It holds a small memory,
// an address pointer, a read latch, a clear sweeper and a registered display mux.
//
//   state    | meaning
//   IDLE     | accepts read/write/inc/dec strobes; clear starts a sweep
//   CLEARING | zeroes one entry per cycle; all strobes ignored
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             hwclk,
  input  logic             reset,
  input  logic             clear,
  input  logic             read,
  input  logic             write,
  input  logic             enable_increment,
  input  logic             enable_decrement,
  input  logic [1:0]       output_select,
  input  logic [WIDTH-1:0] wdata,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] disp_val,
  output logic             busy,
  output logic             clear_done
);

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_disp;
  logic             r_busy;
  logic             r_clear_done;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_idle_cmd;
  logic             w_last;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_addr_ext;
  logic [WIDTH-1:0] w_status;

  // Normal commands only count in IDLE, and only when clear is not also asserted.
  assign w_idle_cmd = (r_state == IDLE) && !clear;
  assign w_last     = (r_state == CLEARING) && (r_idx == AW'(DEPTH - 1));

  addr_counter #(.AW(AW)) u_addr (
    .hwclk     (hwclk),
    .reset     (reset),
    .inc       (w_idle_cmd && enable_increment),
    .dec       (w_idle_cmd && enable_decrement),
    .load_zero (w_last),
    .count     (w_addr)
  );

  // The zero-extended pointer is reused by the status byte. There, the
  // top two bits overwrite any address bits that do not fit.
  assign w_addr_ext = WIDTH'(w_addr);
  assign w_status   = {r_busy, r_clear_done, w_addr_ext[WIDTH-3:0]};

  // Control FSM with registered busy, clear_done and read latch.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state <= CLEARING;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end else if (read) begin
            r_rdata <= r_mem[w_addr];
          end
        end
        CLEARING: begin
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_rdata      <= '0;
            r_clear_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The memory has no reset. Reset only blocks writes, so a sweep cut
  // short by reset leaves its unswept entries untouched.
  always_ff @(posedge hwclk) begin
    if (!reset) begin
      if (r_state == CLEARING) begin
        r_mem[r_idx] <= '0;
      end else if (w_idle_cmd && write) begin
        r_mem[w_addr] <= wdata;
      end
    end
  end

  // Display register. It follows the selected source one cycle late.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_disp <= '0;
    end else begin
      case (output_select)
        SEL_ADDR:   r_disp <= w_addr_ext;
        SEL_RDATA:  r_disp <= r_rdata;
        SEL_WDATA:  r_disp <= wdata;
        SEL_STATUS: r_disp <= w_status;
        default:    r_disp <= '0;
      endcase
    end
  end

  assign addr       = w_addr;
  assign rdata      = r_rdata;
  assign disp_val   = r_disp;
  assign busy       = r_busy;
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl (DEPTH=16, WIDTH=8).
module tb_regfile_ctrl;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       read  = 1'b0;
  logic       write = 1'b0;
  logic       inc   = 1'b0;
  logic       dec   = 1'b0;
  logic [1:0] sel   = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [3:0] addr;
  logic [7:0] rdata;
  logic [7:0] disp_val;
  logic       busy;
  logic       clear_done;

  int total = 0;
  int bad   = 0;

  regfile_ctrl #(.DEPTH(16), .WIDTH(8)) dut (
    .hwclk            (hwclk),
    .reset            (reset),
    .clear            (clear),
    .read             (read),
    .write            (write),
    .enable_increment (inc),
    .enable_decrement (dec),
    .output_select    (sel),
    .wdata            (wdata),
    .addr             (addr),
    .rdata            (rdata),
    .disp_val         (disp_val),
    .busy             (busy),
    .clear_done       (clear_done)
  );

  always #5 hwclk = ~hwclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before test completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel   = 2'd0;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", clear_done); end
    total++; if (addr !== 4'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", addr); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", rdata); end
    reset = 1'b0;
    step();
    total++; if (disp_val !== 8'h00) begin bad++; $display("FAIL rst_disp got=%0h exp=00", disp_val); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy2 got=%0b exp=0", busy); end
  endtask

  task automatic test_inc();
    inc = 1'b1;
    step(); step(); step();
    inc = 1'b0;
    total++; if (addr !== 4'h3) begin bad++; $display("FAIL inc_addr got=%0h exp=3", addr); end
    step();
    total++; if (disp_val !== 8'h03) begin bad++; $display("FAIL inc_disp got=%0h exp=03", disp_val); end
  endtask

  task automatic test_write_read();
    wdata = 8'hA5;
    write = 1'b1;
    step();
    write = 1'b0;
    read  = 1'b1;
    step();
    read  = 1'b0;
    total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL wr_rd_rdata got=%0h exp=a5", rdata); end
    total++; if (addr !== 4'h3) begin bad++; $display("FAIL wr_rd_addr got=%0h exp=3", addr); end
    sel = 2'd1;
    step();
    total++; if (disp_val !== 8'hA5) begin bad++; $display("FAIL sel_rdata_disp got=%0h exp=a5", disp_val); end
  endtask

  task automatic test_wrap();
    dec = 1'b1;
    step(); step(); step();
    total++; if (addr !== 4'h0) begin bad++; $display("FAIL wrap_pre got=%0h exp=0", addr); end
    step();
    dec = 1'b0;
    total++; if (addr !== 4'hF) begin bad++; $display("FAIL wrap_dec got=%0h exp=f", addr); end
    inc = 1'b1;
    step();
    total++; if (addr !== 4'h0) begin bad++; $display("FAIL wrap_inc got=%0h exp=0", addr); end
    for (int i = 0; i < 7; i++) step();
    dec = 1'b1;
    step();
    inc = 1'b0;
    dec = 1'b0;
    total++; if (addr !== 4'h7) begin bad++; $display("FAIL inc_dec_hold got=%0h exp=7", addr); end
  endtask

  task automatic test_write_inc();
    dec = 1'b1;
    step(); step(); step();
    dec = 1'b0;
    wdata = 8'h3C;
    write = 1'b1;
    inc   = 1'b1;
    step();
    write = 1'b0;
    inc   = 1'b0;
    total++; if (addr !== 4'h5) begin bad++; $display("FAIL wr_inc_addr got=%0h exp=5", addr); end
    dec = 1'b1;
    step();
    dec  = 1'b0;
    read = 1'b1;
    step();
    read = 1'b0;
    total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL wr_inc_rdata got=%0h exp=3c", rdata); end
    wdata = 8'h77;
    write = 1'b1;
    read  = 1'b1;
    step();
    write = 1'b0;
    total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL rw_same_old got=%0h exp=3c", rdata); end
    step();
    read = 1'b0;
    total++; if (rdata !== 8'h77) begin bad++; $display("FAIL rw_same_new got=%0h exp=77", rdata); end
    sel   = 2'd2;
    wdata = 8'h99;
    step();
    total++; if (disp_val !== 8'h99) begin bad++; $display("FAIL sel_wdata_disp got=%0h exp=99", disp_val); end
  endtask

  task automatic test_clear();
    int cnt;
    int dn;
    dec = 1'b1;
    step(); step(); step(); step();
    dec = 1'b0;
    write = 1'b1;
    inc   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'h10 + 8'(i);
      step();
    end
    write = 1'b0;
    inc   = 1'b0;
    total++; if (addr !== 4'h0) begin bad++; $display("FAIL fill_addr got=%0h exp=0", addr); end
    sel   = 2'd3;
    clear = 1'b1;
    step();
    clear = 1'b0;
    write = 1'b1;
    inc   = 1'b1;
    wdata = 8'hFF;
    cnt = 0;
    dn  = 0;
    for (int k = 0; k < 24; k++) begin
      if (clear_done === 1'b1) dn++;
      if (busy === 1'b1) begin
        cnt++;
        total++; if (addr !== 4'h0) begin bad++; $display("FAIL sweep_addr_hold got=%0h exp=0", addr); end
        if (cnt == 5) begin
          total++; if (disp_val !== 8'h80) begin bad++; $display("FAIL status_disp got=%0h exp=80", disp_val); end
        end
      end else begin
        write = 1'b0;
        inc   = 1'b0;
      end
      step();
    end
    total++; if (cnt != 16) begin bad++; $display("FAIL busy_cycles got=%0d exp=16", cnt); end
    total++; if (dn != 1) begin bad++; $display("FAIL done_pulses got=%0d exp=1", dn); end
    total++; if (addr !== 4'h0) begin bad++; $display("FAIL clear_addr got=%0h exp=0", addr); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL clear_rdata got=%0h exp=0", rdata); end
    read = 1'b1;
    inc  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL cleared_entry%0d got=%0h exp=00", i, rdata); end
    end
    read = 1'b0;
    inc  = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    write = 1'b1;
    inc   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'h20 + 8'(i);
      step();
    end
    write = 1'b0;
    inc   = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step(); step(); step(); step(); step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midsweep_busy got=%0b exp=1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%0b exp=0", clear_done); end
    total++; if (addr !== 4'h0) begin bad++; $display("FAIL midrst_addr got=%0h exp=0", addr); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_noresume got=%0b exp=0", busy); end
    read = 1'b1;
    inc  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      if (i < 5) begin
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL partial_clr%0d got=%0h exp=00", i, rdata); end
      end else if (i > 5) begin
        total++; if (rdata !== 8'h20 + 8'(i)) begin bad++; $display("FAIL kept%0d got=%0h exp=%0h", i, rdata, 8'h20 + 8'(i)); end
      end
    end
    read = 1'b0;
    inc  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inc();
    test_write_read();
    test_wrap();
    test_write_inc();
    test_clear();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
